// File: rtl/counter_updown_mod.sv
// Up/down counter with a runtime terminal value, wrap or saturate behaviour,
// a range-checked synchronous load, and registered one-cycle event pulses.
module counter_updown_mod #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic             up_down,
    input  logic             count_en,
    input  logic             sat_mode,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             wrap,
    output logic             sat,
    output logic             load_err
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             sat_q, sat_d;
    logic             load_err_q, load_err_d;

    // Next-state selection: load beats count enable, which beats hold.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        sat_d      = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (in > limit) begin
                count_d    = limit;
                load_err_d = 1'b1;
            end else begin
                count_d = in;
            end
        end else if (count_en) begin
            if (up_down) begin
                // ">=" rather than "==" so a count stranded above a lowered
                // limit is pulled back into range on the next up-step.
                if (count_q >= limit) begin
                    if (sat_mode) begin
                        count_d = limit;
                        sat_d   = 1'b1;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                // Down-steps are never clamped to limit, even when above it.
                if (count_q == '0) begin
                    if (sat_mode) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = limit;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // State and event-pulse registers, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            sat_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            sat_q      <= sat_d;
            load_err_q <= load_err_d;
        end
    end

    // Terminal indicator tracks the live direction input.
    always_comb begin
        carry = up_down ? (count_q >= limit) : (count_q == '0);
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign sat      = sat_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_counter_updown_mod.sv
module tb_counter_updown_mod;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din, lim;
    logic       ld, ud, en, sm;
    logic [7:0] cnt;
    logic       carry, wrap, sat, lerr;

    logic [3:0] din4, lim4;
    logic       ld4, ud4, en4, sm4;
    logic [3:0] cnt4;
    logic       carry4, wrap4, sat4, lerr4;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] count;
        logic       carry;
        logic       wrap;
        logic       sat;
        logic       lerr;
    } exp_t;

    exp_t sb8[$];
    exp_t sb4[$];

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(8)) u8 (
        .clk(clk), .reset(reset), .in(din), .limit(lim), .load(ld),
        .up_down(ud), .count_en(en), .sat_mode(sm), .count(cnt),
        .carry(carry), .wrap(wrap), .sat(sat), .load_err(lerr)
    );

    counter_updown_mod #(.WIDTH(4)) u4 (
        .clk(clk), .reset(reset), .in(din4), .limit(lim4), .load(ld4),
        .up_down(ud4), .count_en(en4), .sat_mode(sm4), .count(cnt4),
        .carry(carry4), .wrap(wrap4), .sat(sat4), .load_err(lerr4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the 8-bit instance, queue the expectation, compare after the edge.
    task automatic step8(input logic l, input logic e, input logic u, input logic s,
                         input logic [7:0] d, input logic [7:0] lm,
                         input logic [7:0] ec, input logic ew, input logic es,
                         input logic el, input string tag);
        exp_t x;
        ld = l; en = e; ud = u; sm = s; din = d; lim = lm;
        sb8.push_back('{count: ec, carry: (u ? (ec >= lm) : (ec == 8'd0)),
                        wrap: ew, sat: es, lerr: el});
        @(posedge clk);
        #1;
        x = sb8.pop_front();
        chk({tag, ".count"}, 32'(cnt), 32'(x.count));
        chk({tag, ".carry"}, 32'(carry), 32'(x.carry));
        chk({tag, ".wrap"}, 32'(wrap), 32'(x.wrap));
        chk({tag, ".sat"}, 32'(sat), 32'(x.sat));
        chk({tag, ".load_err"}, 32'(lerr), 32'(x.lerr));
    endtask

    task automatic step4(input logic e, input logic [3:0] lm,
                         input logic [3:0] ec, input logic ew, input string tag);
        exp_t x;
        ld4 = 1'b0; en4 = e; ud4 = 1'b1; sm4 = 1'b0; din4 = 4'd0; lim4 = lm;
        sb4.push_back('{count: {4'd0, ec}, carry: (ec >= lm), wrap: ew, sat: 1'b0, lerr: 1'b0});
        @(posedge clk);
        #1;
        x = sb4.pop_front();
        chk({tag, ".count"}, 32'(cnt4), 32'(x.count));
        chk({tag, ".carry"}, 32'(carry4), 32'(x.carry));
        chk({tag, ".wrap"}, 32'(wrap4), 32'(x.wrap));
        chk({tag, ".sat"}, 32'(sat4), 32'(x.sat));
    endtask

    initial begin
        reset = 1'b1;
        din = 8'd0; lim = 8'd9; ld = 1'b0; ud = 1'b1; en = 1'b0; sm = 1'b0;
        din4 = 4'd0; lim4 = 4'd15; ld4 = 1'b0; ud4 = 1'b1; en4 = 1'b0; sm4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", 32'(cnt), 32'd0);
        chk("rst.wrap", 32'(wrap), 32'd0);
        chk("rst.sat", 32'(sat), 32'd0);
        chk("rst.load_err", 32'(lerr), 32'd0);
        chk("rst.carry_up", 32'(carry), 32'd0);
        ud = 1'b0;
        #1;
        chk("rst.carry_down", 32'(carry), 32'd1);
        ud = 1'b1; lim = 8'd0;
        #1;
        chk("rst.carry_lim0", 32'(carry), 32'd1);
        lim = 8'd9;
        #1;
        reset = 1'b0;

        // Wrap-mode count up, limit 9.
        for (int i = 1; i <= 12; i++)
            step8(0, 1, 1, 0, 8'd0, 8'd9, 8'((i <= 9) ? i : i - 10), (i == 10), 0, 0, "up_wrap");

        // Saturate-mode count up from 0.
        step8(1, 0, 1, 1, 8'd0, 8'd9, 8'd0, 0, 0, 0, "load0");
        for (int i = 1; i <= 12; i++)
            step8(0, 1, 1, 1, 8'd0, 8'd9, 8'((i <= 9) ? i : 9), 0, (i >= 10), 0, "up_sat");

        // Load 3 then count down in wrap mode.
        step8(1, 0, 1, 0, 8'd3, 8'd9, 8'd3, 0, 0, 0, "load3");
        step8(0, 1, 0, 0, 8'd0, 8'd9, 8'd2, 0, 0, 0, "down1");
        step8(0, 1, 0, 0, 8'd0, 8'd9, 8'd1, 0, 0, 0, "down2");
        step8(0, 1, 0, 0, 8'd0, 8'd9, 8'd0, 0, 0, 0, "down3");
        step8(0, 1, 0, 0, 8'd0, 8'd9, 8'd9, 1, 0, 0, "down4");
        step8(0, 1, 0, 0, 8'd0, 8'd9, 8'd8, 0, 0, 0, "down5");
        step8(0, 1, 0, 1, 8'd0, 8'd9, 8'd7, 0, 0, 0, "down_sat_mode");

        // Out-of-range load with count_en also high.
        step8(1, 1, 1, 0, 8'd200, 8'd100, 8'd100, 0, 0, 1, "load_over");
        step8(0, 0, 1, 0, 8'd0, 8'd100, 8'd100, 0, 0, 0, "hold");

        // Limit lowered below the count.
        step8(1, 0, 1, 0, 8'd50, 8'd100, 8'd50, 0, 0, 0, "load50a");
        step8(0, 0, 1, 0, 8'd0, 8'd20, 8'd50, 0, 0, 0, "lim_drop_hold");
        step8(0, 1, 1, 0, 8'd0, 8'd20, 8'd0, 1, 0, 0, "lim_drop_wrap");
        step8(1, 0, 1, 1, 8'd50, 8'd100, 8'd50, 0, 0, 0, "load50b");
        step8(0, 1, 1, 1, 8'd0, 8'd20, 8'd20, 0, 1, 0, "lim_drop_sat");
        step8(1, 0, 1, 0, 8'd50, 8'd100, 8'd50, 0, 0, 0, "load50c");
        step8(0, 1, 0, 0, 8'd0, 8'd20, 8'd49, 0, 0, 0, "down_above_lim");

        // Degenerate limit of zero: back-to-back pulses.
        step8(1, 0, 1, 0, 8'd0, 8'd0, 8'd0, 0, 0, 0, "lim0_load");
        step8(0, 1, 1, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0, "lim0_wrap1");
        step8(0, 1, 0, 0, 8'd0, 8'd0, 8'd0, 1, 0, 0, "lim0_wrap2");
        step8(0, 1, 1, 1, 8'd0, 8'd0, 8'd0, 0, 1, 0, "lim0_sat");

        // Asynchronous reset while a wrap pulse is showing.
        step8(1, 0, 0, 0, 8'd0, 8'd7, 8'd0, 0, 0, 0, "pre_rst_load");
        step8(0, 1, 0, 0, 8'd0, 8'd7, 8'd7, 1, 0, 0, "pre_rst_wrap");
        en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst.count", 32'(cnt), 32'd0);
        chk("async_rst.wrap", 32'(wrap), 32'd0);
        #1;
        reset = 1'b0;
        @(negedge clk);
        step8(0, 1, 1, 0, 8'd0, 8'd7, 8'd1, 0, 0, 0, "post_rst_step");

        // 4-bit instance run to its maximum.
        for (int i = 1; i <= 17; i++)
            step4(1, 4'd15, 4'((i <= 15) ? i : i - 16), (i == 16), "w4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
